mult_arb: RTL and testbench
===========================

# mult_arb

Round-robin arbiter and sequencer that shares one iterative shift-add multiplier (N×M bits, one multiplier bit per cycle) between R requesters. Each requester presents operands with a valid/ready handshake; the block grants one, runs the multiply to completion, and returns the product tagged with the requester index on a single result channel with backpressure. It sits between multiple datapath clients and the single multiplier engine.

## Interface
- `N`, default 4: width of `mult1` operands.
- `M`, default 4: width of `mult2` operands; it is also the multiply latency in RUN cycles.
- `R`, default 2: number of requesters, legal range 2..8.
- `ID_W`, derived as max(1, clog2(R)): width of the requester tag.

- `clk`, in, 1: single clock, rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `req_vld`, in, R: per-requester operand valid.
- `req_rdy`, out, R: per-requester accept; at most one bit is high.
- `req_mult1`, in, R*N: flattened multiplicands; requester i uses bits [i*N +: N].
- `req_mult2`, in, R*M: flattened multipliers; requester i uses bits [i*M +: M].
- `res_vld`, out, 1: product valid.
- `res_ack`, in, 1: consumer accepts the product.
- `res`, out, N+M: unsigned product.
- `res_id`, out, ID_W: index of the requester that owns `res`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - If any `req_vld` bit is high, the grant goes to the first valid index after `last_gnt`, searching upward with wrap-around.
  - `req_rdy[g]` is asserted combinationally.
  - On the edge, the block captures the operands from requester g and sets `res_id`←g and `last_gnt`←g. It zeroes the accumulator, sets `cnt`←0 and moves to RUN.
- **RUN**
  - Each cycle: if the multiplier LSB is 1, the accumulator adds the shifted multiplicand. The multiplicand then shifts left and the multiplier shifts right. `cnt` increments.
  - When `cnt`==M-1 on an edge, the state moves to DONE and `res` is loaded with the final accumulator.
- **DONE**
  - `res_vld`=1, and `res` and `res_id` stay stable.
  - When `res_ack`=1 on an edge, the state moves to IDLE and `res_vld` clears.
- Arithmetic is unsigned. The product always fits in N+M bits, so there is no overflow. The accumulator and shifted multiplicand are N+M bits wide.
- `req_rdy` is 0 in RUN and DONE, and also while `rstn`=0; it is gated with `rstn`.
- Requesters must hold `req_vld` and their operands stable until accepted. Dropping `req_vld` before acceptance has no side effect.
- `last_gnt` updates only on acceptance. Its reset value is R-1, so requester 0 wins the first arbitration.
- Reset asserted mid-operation aborts the operation and discards the result; nothing is replayed.

## Timing
- **Reset values:** `req_rdy`=0, `res_vld`=0, `res`=0, `res_id`=0, state=IDLE, `cnt`=0, `last_gnt`=R-1.
- **Latency:** with acceptance on edge E0, `res_vld` rises after edge E0+M and is visible in the cycle following it. The latency is fixed at M regardless of operand values, including zero.
- **Throughput:** with `res_ack` tied high, the minimum accept-to-accept spacing is M+2 cycles (1 IDLE + M RUN + 1 DONE).
- **Simultaneous events:**
  - `res_ack` is ignored outside DONE.
  - New requests arriving during RUN or DONE wait; their arbitration uses the `last_gnt` in effect at the next IDLE cycle.
- **Fairness:** with all R requesters continuously valid, grants cycle 0,1,…,R-1,0 with no starvation.

## Structure
- Shared package `mult_arb_pkg` holds:
  - the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the `ID_W` derivation function (clog2 with a minimum of 1).
- One sub-module: `mult_seq_core`, the shift-add engine. Its ports are `start`, `mult1`, `mult2`, `busy`, `done` (one-cycle pulse) and `product`. It owns `cnt` and the shift/accumulate registers.
- The top level owns the round-robin grant logic, the FSM, the result registers and the handshakes.

## Test plan
- **Single request:** N=M=4, R=2, requester 0 sends 7×9 and is accepted at E0 → `res_vld` becomes visible after edge E0+4, `res`=63, `res_id`=0, `req_rdy`=0 during RUN.
- **Contention:** both requesters valid after reset, requester 0 sends 3×5 and requester 1 sends 15×15 → results come back 15 with id 0, then 225 with id 1. With both valid again, the grants alternate 0,1,0,1.
- **Backpressure:** `res_ack` held low for 5 cycles in DONE → `res`, `res_id` and `res_vld` stay stable, `req_rdy` stays 0, and the next grant occurs the cycle after acceptance.
- **Zero and maximum operands:** 15×0 → `res`=0 with latency still 4; 15×15 → `res`=225 (8'hE1).
- **Reset mid-RUN:** assert `rstn` low in the second RUN cycle → all outputs drop to 0 immediately. After release, with both requesters valid, requester 0 is granted first and produces a correct fresh result.
- **Withdrawn request:** requester 1 raises then drops `req_vld` while the block is in RUN → it gets no grant and no result, and requester 0's operation completes normally.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared state encodings and tag-width helper for the multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester tag width; never narrower than one bit.
    function automatic int calc_id_w(input int r);
        return (r > 2) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Latency: M cycles from start to the done pulse; product is valid alongside done.
// Backpressure: none; the caller must register product when done pulses.
module mult_seq_core
    import mult_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic [N-1:0]   mult1,
    input  logic [M-1:0]   mult2,
    output logic           busy,
    output logic           done,
    output logic [N+M-1:0] product
);

    localparam int W     = N + M;
    localparam int CNT_W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0]     acc;
    logic [W-1:0]     mcand;
    logic [M-1:0]     mplr;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [W-1:0]     acc_nxt;

    assign acc_nxt = acc + (mplr[0] ? mcand : '0);
    assign done    = busy_q && (cnt == CNT_W'(M - 1));
    // Product includes the last partial product so it is ready on the final edge.
    assign product = acc_nxt;
    assign busy    = busy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= W'(mult1);
            mplr   <= mult2;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one shift-add multiplier among R requesters.
// Latency: result valid M cycles after the accepting edge; accept-to-accept >= M+2.
// Backpressure: result held in DONE until res_ack; no requests accepted meanwhile.
module mult_arb
    import mult_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int R    = 2,
    parameter int ID_W = calc_id_w(R)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [R-1:0]   req_vld,
    output logic [R-1:0]   req_rdy,
    input  logic [R*N-1:0] req_mult1,
    input  logic [R*M-1:0] req_mult2,
    output logic           res_vld,
    input  logic           res_ack,
    output logic [N+M-1:0] res,
    output logic [ID_W-1:0] res_id
);

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_gnt;
    logic [ID_W-1:0] hi_gnt, lo_gnt, gnt;
    logic            hi_vld, lo_vld, gnt_vld;
    logic [N-1:0]    sel1;
    logic [M-1:0]    sel2;
    logic            accept;
    logic            core_busy, core_done;
    logic [N+M-1:0]  core_product;

    // Lowest valid index above last_gnt wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_gnt = '0;
        hi_vld = 1'b0;
        lo_gnt = '0;
        lo_vld = 1'b0;
        for (int i = R - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                lo_gnt = ID_W'(i);
                lo_vld = 1'b1;
                if (ID_W'(i) > last_gnt) begin
                    hi_gnt = ID_W'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        gnt     = hi_vld ? hi_gnt : lo_gnt;
        gnt_vld = hi_vld | lo_vld;
    end

    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int i = 0; i < R; i++) begin
            if (ID_W'(i) == gnt) begin
                sel1 = req_mult1[i*N +: N];
                sel2 = req_mult2[i*M +: M];
            end
        end
    end

    assign accept = (state == IDLE) && gnt_vld && !core_busy;

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < R; i++) begin
            req_rdy[i] = accept && rstn && (ID_W'(i) == gnt);
        end
    end

    mult_seq_core #(.N(N), .M(M)) u_core (
        .clk     (clk),
        .rstn    (rstn),
        .start   (accept),
        .mult1   (sel1),
        .mult2   (sel2),
        .busy    (core_busy),
        .done    (core_done),
        .product (core_product)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (core_done) state_nxt = DONE;
            DONE:    if (res_ack)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt <= ID_W'(R - 1);
            res      <= '0;
            res_id   <= '0;
        end else begin
            if (accept) begin
                last_gnt <= gnt;
                res_id   <= gnt;
            end
            if (state == RUN && core_done) begin
                res <= core_product;
            end
        end
    end

    assign res_vld = (state == DONE);

endmodule

// File: tb/tb_mult_arb.sv
// Directed bench for mult_arb with N=M=4, R=2 and hand-computed products.
module tb_mult_arb;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] req_vld;
    logic [1:0] req_rdy;
    logic [7:0] req_mult1;
    logic [7:0] req_mult2;
    logic       res_vld;
    logic       res_ack;
    logic [7:0] res;
    logic       res_id;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mult_arb #(.N(4), .M(4), .R(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_mult1 (req_mult1),
        .req_mult2 (req_mult2),
        .res_vld   (res_vld),
        .res_ack   (res_ack),
        .res       (res),
        .res_id    (res_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    // Single isolated request from requester idx, checked for latency and value.
    task automatic run_one(input int idx, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp_res, input string tag);
        req_mult1[idx*4 +: 4] = a;
        req_mult2[idx*4 +: 4] = b;
        req_vld = 2'b01 << idx;
        #1;
        chk({tag, "_rdy"}, 32'(req_rdy), 32'(2'b01 << idx));
        tick();
        req_vld = 2'b00;
        repeat (3) begin
            tick();
            chk({tag, "_run_vld"}, 32'(res_vld), 32'd0);
            chk({tag, "_run_rdy"}, 32'(req_rdy), 32'd0);
        end
        tick();
        chk({tag, "_vld"}, 32'(res_vld), 32'd1);
        chk({tag, "_res"}, 32'(res), 32'(exp_res));
        chk({tag, "_id"},  32'(res_id), 32'(idx));
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk({tag, "_ack_vld"}, 32'(res_vld), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        req_vld   = 2'b11;
        req_mult1 = 8'h00;
        req_mult2 = 8'h00;
        res_ack   = 1'b0;
        tick();
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_vld", 32'(res_vld), 32'd0);
        chk("rst_res", 32'(res),     32'd0);
        chk("rst_id",  32'(res_id),  32'd0);
        req_vld = 2'b00;
        rstn = 1'b1;
        #1;

        // Single request 7x9 from requester 0.
        run_one(0, 4'd7, 4'd9, 8'd63, "single");

        // Contention after reset: requester 0 first, then 1.
        do_reset();
        req_mult1 = {4'd15, 4'd3};
        req_mult2 = {4'd15, 4'd5};
        req_vld   = 2'b11;
        #1;
        chk("cont_rdy0", 32'(req_rdy), 32'b01);
        tick();
        req_vld = 2'b10;
        repeat (4) tick();
        chk("cont_res0", 32'(res),    32'd15);
        chk("cont_id0",  32'(res_id), 32'd0);
        res_ack = 1'b1;
        tick();
        chk("cont_rdy1", 32'(req_rdy), 32'b10);
        tick();
        req_vld = 2'b00;
        repeat (4) tick();
        chk("cont_res1", 32'(res),    32'd225);
        chk("cont_id1",  32'(res_id), 32'd1);
        tick();

        // Both continuously valid with res_ack high: grants alternate 0,1,0,1.
        req_vld = 2'b11;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("alt_rdy", 32'(req_rdy), 32'(2'b01 << (g % 2)));
            repeat (5) tick();
            chk("alt_vld", 32'(res_vld), 32'd1);
            chk("alt_id",  32'(res_id),  32'(g % 2));
            chk("alt_res", 32'(res),     (g % 2) ? 32'd225 : 32'd15);
            tick();
        end
        req_vld = 2'b00;
        res_ack = 1'b0;
        #1;

        // Backpressure: hold DONE for 5 cycles with requester 1 pending.
        req_mult1 = {4'd15, 4'd2};
        req_mult2 = {4'd15, 4'd6};
        req_vld   = 2'b01;
        #1;
        chk("bp_rdy0", 32'(req_rdy), 32'b01);
        tick();
        req_vld = 2'b10;
        repeat (4) tick();
        chk("bp_res", 32'(res), 32'd12);
        repeat (5) begin
            tick();
            chk("bp_hold_vld", 32'(res_vld), 32'd1);
            chk("bp_hold_res", 32'(res),     32'd12);
            chk("bp_hold_id",  32'(res_id),  32'd0);
            chk("bp_hold_rdy", 32'(req_rdy), 32'd0);
        end
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk("bp_ack_vld", 32'(res_vld), 32'd0);
        chk("bp_next_rdy", 32'(req_rdy), 32'b10);
        tick();
        req_vld = 2'b00;
        repeat (4) tick();
        chk("bp_res1", 32'(res),    32'd225);
        chk("bp_id1",  32'(res_id), 32'd1);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;

        // Zero and maximum operands.
        run_one(0, 4'd15, 4'd0,  8'd0,   "zero");
        run_one(0, 4'd15, 4'd15, 8'hE1,  "max");

        // Reset in the second RUN cycle of a requester-1 operation.
        req_mult1[7:4] = 4'd5;
        req_mult2[7:4] = 4'd5;
        req_vld = 2'b10;
        #1;
        chk("mid_rdy", 32'(req_rdy), 32'b10);
        tick();
        tick();
        req_vld = 2'b11;
        rstn = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(res_vld), 32'd0);
        chk("mid_rst_res", 32'(res),     32'd0);
        chk("mid_rst_id",  32'(res_id),  32'd0);
        chk("mid_rst_rdy", 32'(req_rdy), 32'd0);
        tick();
        rstn = 1'b1;
        #1;
        chk("post_rst_rdy", 32'(req_rdy), 32'b01);
        run_one(0, 4'd6, 4'd7, 8'd42, "post_rst");

        // Requester 1 raises then drops req_vld during requester 0's RUN.
        req_mult1[3:0] = 4'd9;
        req_mult2[3:0] = 4'd3;
        req_vld = 2'b01;
        tick();
        req_vld = 2'b00;
        tick();
        req_vld = 2'b10;
        tick();
        req_vld = 2'b00;
        tick();
        tick();
        chk("wd_vld", 32'(res_vld), 32'd1);
        chk("wd_res", 32'(res),     32'd27);
        chk("wd_id",  32'(res_id),  32'd0);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        repeat (3) begin
            chk("wd_no_rdy", 32'(req_rdy), 32'd0);
            chk("wd_no_vld", 32'(res_vld), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
